// File: rtl/vm_pkg.sv
// Shared types and helpers for the parametrised voting machine.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    WAIT_REL = 2'd2,
    REJECT   = 2'd3
  } vm_state_e;

  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;

  // Counters up to 32 bits wide are widened to this width for the helper.
  localparam int SAT_W = 32;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_val);
    return (value >= max_val) ? value : value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/vm_max_resolver.sv
// Combinational argmax over the candidate tallies (lowest index wins ties)
// plus detection of a shared non-zero maximum.
module vm_max_resolver #(
  parameter int N_CAND  = 4,
  parameter int COUNT_W = 8,
  parameter int IDX_W   = 2
) (
  input  logic [N_CAND-1:0][COUNT_W-1:0] tally_i,
  output logic [IDX_W-1:0]               idx_o,
  output logic                           tie_o
);

  logic [COUNT_W-1:0] max_val;

  always_comb begin
    max_val = tally_i[0];
    idx_o   = '0;
    tie_o   = 1'b0;
    // Strict compare keeps the earliest candidate among equals.
    for (int i = 1; i < N_CAND; i++) begin
      if (tally_i[i] > max_val) begin
        max_val = tally_i[i];
        idx_o   = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_CAND; i++) begin
      if ((tally_i[i] == max_val) && (IDX_W'(i) != idx_o)) begin
        tie_o = 1'b1;
      end
    end
    if (max_val == '0) begin
      tie_o = 1'b0;
    end
  end

endmodule

// File: rtl/voting_machine_param.sv
// Debounced one-vote-per-press voting machine with saturating tallies,
// result readout on the LED bank and a registered winner/tie resolver.
module voting_machine_param
  import vm_pkg::*;
#(
  parameter  int N_CAND       = 4,
  parameter  int COUNT_W      = 8,
  parameter  int DEBOUNCE_CYC = 10,
  localparam int IDX_W        = (N_CAND > 1) ? $clog2(N_CAND) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [N_CAND-1:0]  button,
  output logic [COUNT_W-1:0] led,
  output logic               vote_ack,
  output logic               reject,
  output logic [COUNT_W-1:0] total,
  output logic [IDX_W-1:0]   winner,
  output logic               winner_valid,
  output logic               tie
);

  localparam int                 HOLD_W  = $clog2(DEBOUNCE_CYC);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  vm_state_e                     state_q;
  logic [IDX_W-1:0]              idx_q;
  logic [HOLD_W-1:0]             hold_q;
  logic [N_CAND-1:0][COUNT_W-1:0] tally_q;
  logic [COUNT_W-1:0]            total_q;
  logic [COUNT_W-1:0]            led_q;
  logic                          vote_ack_q;
  logic                          reject_q;
  logic [IDX_W-1:0]              winner_q;
  logic                          winner_valid_q;
  logic                          tie_q;

  logic                          single_press;
  logic [IDX_W-1:0]              press_idx;
  logic [N_CAND-1:0]             latched_mask;
  logic [COUNT_W-1:0]            led_d;
  logic [IDX_W-1:0]              res_idx;
  logic                          res_tie;

  always_comb begin
    single_press = (button != '0) && ((button & (button - N_CAND'(1))) == '0);
    press_idx    = '0;
    for (int i = N_CAND - 1; i >= 0; i--) begin
      if (button[i]) begin
        press_idx = IDX_W'(i);
      end
    end
    latched_mask = N_CAND'(1) << idx_q;
  end

  // Vote mode shows the candidate being captured; result mode shows the
  // tally of the lowest-index pressed button.
  always_comb begin
    led_d = '0;
    if (mode == MODE_RESULT) begin
      for (int i = N_CAND - 1; i >= 0; i--) begin
        if (button[i]) begin
          led_d = tally_q[i];
        end
      end
    end else if ((state_q == ARMING) || (state_q == WAIT_REL)) begin
      for (int i = 0; i < COUNT_W; i++) begin
        if (i == int'(idx_q)) begin
          led_d[i] = 1'b1;
        end
      end
    end
  end

  vm_max_resolver #(
    .N_CAND (N_CAND),
    .COUNT_W(COUNT_W),
    .IDX_W  (IDX_W)
  ) u_resolver (
    .tally_i(tally_q),
    .idx_o  (res_idx),
    .tie_o  (res_tie)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      hold_q         <= '0;
      tally_q        <= '0;
      total_q        <= '0;
      led_q          <= '0;
      vote_ack_q     <= 1'b0;
      reject_q       <= 1'b0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      tie_q          <= 1'b0;
    end else begin
      vote_ack_q <= 1'b0;
      reject_q   <= 1'b0;
      if (mode == MODE_VOTE) begin
        case (state_q)
          IDLE: begin
            if (single_press) begin
              state_q <= ARMING;
              idx_q   <= press_idx;
              hold_q  <= HOLD_W'(1);
            end else if (button != '0) begin
              state_q  <= REJECT;
              reject_q <= 1'b1;
            end
          end
          ARMING: begin
            if (button == '0) begin
              state_q <= IDLE;
              hold_q  <= '0;
            end else if (button != latched_mask) begin
              state_q  <= REJECT;
              reject_q <= 1'b1;
              hold_q   <= '0;
            end else if (hold_q == HOLD_W'(DEBOUNCE_CYC - 1)) begin
              // This edge completes the debounce window: count the vote.
              state_q          <= WAIT_REL;
              hold_q           <= '0;
              vote_ack_q       <= 1'b1;
              tally_q[idx_q]   <= COUNT_W'(sat_inc(SAT_W'(tally_q[idx_q]), SAT_W'(CNT_MAX)));
              total_q          <= COUNT_W'(sat_inc(SAT_W'(total_q), SAT_W'(CNT_MAX)));
            end else begin
              hold_q <= hold_q + HOLD_W'(1);
            end
          end
          WAIT_REL, REJECT: begin
            if (button == '0) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else begin
        state_q <= IDLE;
        hold_q  <= '0;
      end
      led_q          <= led_d;
      winner_valid_q <= (total_q != '0);
      winner_q       <= (total_q != '0) ? res_idx : '0;
      tie_q          <= (total_q != '0) && res_tie;
    end
  end

  assign led          = led_q;
  assign vote_ack     = vote_ack_q;
  assign reject       = reject_q;
  assign total        = total_q;
  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
  assign tie          = tie_q;

endmodule

// File: tb/tb_voting_machine_param.sv
// Directed bench for voting_machine_param: debounce latency, rejection,
// saturation, result readout, winner/tie and mode/reset aborts.
module tb_voting_machine_param;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int DEB = 10;
  localparam int IW  = 2;

  logic          clk;
  logic          rst;
  logic          mode;
  logic [N-1:0]  button;
  logic [W-1:0]  led;
  logic          vote_ack;
  logic          reject;
  logic [W-1:0]  total;
  logic [IW-1:0] winner;
  logic          winner_valid;
  logic          tie;

  int checks = 0;
  int errors = 0;

  voting_machine_param #(
    .N_CAND      (N),
    .COUNT_W     (W),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .button      (button),
    .led         (led),
    .vote_ack    (vote_ack),
    .reject      (reject),
    .total       (total),
    .winner      (winner),
    .winner_valid(winner_valid),
    .tie         (tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; mode = 1'b0; button = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic cast_vote(input int c);
    button = N'(1) << c;
    repeat (DEB) tick();
    button = '0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; mode = 1'b0; button = '0;
    tick(); tick();
    checks++;
    if ({led, vote_ack, reject, total, winner, winner_valid, tie} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got led=%0d ack=%0b rej=%0b total=%0d win=%0d valid=%0b tie=%0b want all 0",
               led, vote_ack, reject, total, winner, winner_valid, tie);
    end
    rst = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_vote();
    do_reset();
    button = 4'b0001;
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (vote_ack !== (e == DEB)) begin
        errors++;
        $display("FAIL single_ack edge %0d got %0b want %0b", e, vote_ack, (e == DEB));
      end
      if (e == 5 || e == 15) begin
        checks++;
        if (led !== 8'h01) begin
          errors++;
          $display("FAIL single_led_onehot edge %0d got %0h want 01", e, led);
        end
      end
    end
    button = '0;
    tick(); tick();
    checks++;
    if (total !== 8'd1 || winner_valid !== 1'b1 || winner !== 2'd0 || tie !== 1'b0) begin
      errors++;
      $display("FAIL single_total got total=%0d valid=%0b win=%0d tie=%0b want 1 1 0 0",
               total, winner_valid, winner, tie);
    end
    mode = 1'b1; button = 4'b0001;
    tick();
    checks++;
    if (led !== 8'd1) begin
      errors++;
      $display("FAIL single_tally0 got %0d want 1", led);
    end
    mode = 1'b0; button = '0;
    tick();
    $display("test_single_vote done");
  endtask

  task automatic test_short_press();
    do_reset();
    button = 4'b0010;
    repeat (5) tick();
    button = '0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (vote_ack !== 1'b0) begin
        errors++;
        $display("FAIL short_ack cycle %0d got %0b want 0", e, vote_ack);
      end
    end
    checks++;
    if (led !== 8'd0 || total !== 8'd0) begin
      errors++;
      $display("FAIL short_idle got led=%0h total=%0d want 0 0", led, total);
    end
    mode = 1'b1; button = 4'b0010;
    tick();
    checks++;
    if (led !== 8'd0) begin
      errors++;
      $display("FAIL short_tally1 got %0d want 0", led);
    end
    mode = 1'b0; button = '0;
    tick();
    button = 4'b0010;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if (vote_ack !== (e == DEB)) begin
        errors++;
        $display("FAIL short_fresh_ack edge %0d got %0b want %0b", e, vote_ack, (e == DEB));
      end
    end
    button = '0;
    tick();
    $display("test_short_press done");
  endtask

  task automatic test_multi_reject();
    do_reset();
    button = 4'b0011;
    tick();
    checks++;
    if (reject !== 1'b1) begin
      errors++;
      $display("FAIL reject_idle got %0b want 1", reject);
    end
    button = '0;
    tick(); tick();
    button = 4'b0100;
    for (int e = 1; e <= 3; e++) begin
      if (e == 3) button = 4'b1100;
      tick();
      checks++;
      if (reject !== (e == 3)) begin
        errors++;
        $display("FAIL reject_join edge %0d got %0b want %0b", e, reject, (e == 3));
      end
    end
    tick();
    checks++;
    if (reject !== 1'b0 || led !== 8'd0) begin
      errors++;
      $display("FAIL reject_single_pulse got rej=%0b led=%0h want 0 0", reject, led);
    end
    button = 4'b0100;
    for (int e = 1; e <= 15; e++) begin
      tick();
      checks++;
      if (vote_ack !== 1'b0) begin
        errors++;
        $display("FAIL reject_hold_ack cycle %0d got %0b want 0", e, vote_ack);
      end
    end
    checks++;
    if (total !== 8'd0) begin
      errors++;
      $display("FAIL reject_total got %0d want 0", total);
    end
    button = '0;
    tick(); tick();
    button = 4'b0100;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if (vote_ack !== (e == DEB)) begin
        errors++;
        $display("FAIL reject_repress_ack edge %0d got %0b want %0b", e, vote_ack, (e == DEB));
      end
    end
    button = '0;
    tick();
    checks++;
    if (total !== 8'd1) begin
      errors++;
      $display("FAIL reject_repress_total got %0d want 1", total);
    end
    $display("test_multi_reject done");
  endtask

  task automatic test_tally_winner();
    int seq [7] = '{0, 1, 0, 2, 1, 1, 0};
    do_reset();
    foreach (seq[k]) cast_vote(seq[k]);
    mode = 1'b1; button = 4'b0001;
    tick();
    checks++;
    if (led !== 8'd3 || total !== 8'd7 || winner !== 2'd0 || tie !== 1'b1 || winner_valid !== 1'b1) begin
      errors++;
      $display("FAIL tally_result got led=%0d total=%0d win=%0d tie=%0b valid=%0b want 3 7 0 1 1",
               led, total, winner, tie, winner_valid);
    end
    button = 4'b0100;
    tick();
    checks++;
    if (led !== 8'd1) begin
      errors++;
      $display("FAIL tally_c got %0d want 1", led);
    end
    button = 4'b0110;
    tick();
    checks++;
    if (led !== 8'd3) begin
      errors++;
      $display("FAIL tally_lowest got %0d want 3", led);
    end
    button = 4'b1000;
    tick();
    checks++;
    if (led !== 8'd0) begin
      errors++;
      $display("FAIL tally_d got %0d want 0", led);
    end
    button = '0;
    tick();
    checks++;
    if (led !== 8'd0) begin
      errors++;
      $display("FAIL tally_none got %0d want 0", led);
    end
    mode = 1'b0;
    tick();
    cast_vote(1);
    checks++;
    if (winner !== 2'd1 || tie !== 1'b0 || total !== 8'd8) begin
      errors++;
      $display("FAIL tally_new_leader got win=%0d tie=%0b total=%0d want 1 0 8", winner, tie, total);
    end
    $display("test_tally_winner done");
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (255) cast_vote(0);
    checks++;
    if (total !== 8'd255) begin
      errors++;
      $display("FAIL sat_preload got %0d want 255", total);
    end
    button = 4'b0001;
    for (int e = 1; e <= DEB; e++) begin
      tick();
      checks++;
      if (vote_ack !== (e == DEB)) begin
        errors++;
        $display("FAIL sat_ack edge %0d got %0b want %0b", e, vote_ack, (e == DEB));
      end
    end
    button = '0;
    tick(); tick();
    checks++;
    if (total !== 8'd255 || winner !== 2'd0 || winner_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_total got total=%0d win=%0d valid=%0b want 255 0 1", total, winner, winner_valid);
    end
    mode = 1'b1; button = 4'b0001;
    tick();
    checks++;
    if (led !== 8'd255) begin
      errors++;
      $display("FAIL sat_tally0 got %0d want 255", led);
    end
    mode = 1'b0; button = '0;
    tick();
    $display("test_saturation done");
  endtask

  task automatic test_mode_abort();
    do_reset();
    button = 4'b0010;
    repeat (6) tick();
    mode = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (vote_ack !== 1'b0 || led !== 8'd0) begin
        errors++;
        $display("FAIL mode_hold cycle %0d got ack=%0b led=%0d want 0 0", e, vote_ack, led);
      end
    end
    mode = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if (vote_ack !== (e == DEB)) begin
        errors++;
        $display("FAIL mode_reentry_ack edge %0d got %0b want %0b", e, vote_ack, (e == DEB));
      end
    end
    button = '0;
    tick();
    checks++;
    if (total !== 8'd1) begin
      errors++;
      $display("FAIL mode_total got %0d want 1", total);
    end
    $display("test_mode_abort done");
  endtask

  task automatic test_reset_mid_arming();
    do_reset();
    cast_vote(0);
    button = 4'b0100;
    repeat (DEB - 1) tick();
    checks++;
    if (led !== 8'h04 || winner_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got led=%0h valid=%0b want 04 1", led, winner_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({led, vote_ack, reject, total, winner, winner_valid, tie} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got led=%0h ack=%0b rej=%0b total=%0d win=%0d valid=%0b tie=%0b want all 0",
               led, vote_ack, reject, total, winner, winner_valid, tie);
    end
    button = '0;
    rst = 1'b1;
    tick();
    $display("test_reset_mid_arming done");
  endtask

  initial begin
    rst = 1'b0; mode = 1'b0; button = '0;
    test_reset();
    test_single_vote();
    test_short_press();
    test_multi_reject();
    test_tally_winner();
    test_saturation();
    test_mode_abort();
    test_reset_mid_arming();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
